div_seq_16bits: RTL and testbench

Sequential 16-bit unsigned restoring divider built around one shared `add_subt_16bits` instance. The instance is hard-wired to subtract mode. The block runs one trial subtraction per clock for 16 clocks, then holds the quotient and remainder until the next start. It is the first multi-cycle consumer of the add/subtract datapath and sits beside it in the arithmetic unit.

---
 rtl/arith_pkg.sv | 18 +
 rtl/add_subt_16bits.sv | 24 ++
 rtl/div_seq_16bits.sv | 128 ++++++++++++
 tb/tb_div_seq_16bits.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit.
//   WIDTH  : datapath width of the add/subtract unit and the divider
//   ITER   : number of restoring-division iterations (one per quotient bit)
//   CNT_W  : width of the iteration counter (holds 0..ITER)
//   state_e: divider control states
package arith_pkg;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_subt_16bits.sv
// 16-bit combinational adder/subtractor.
//   op0, op1 : operands
//   x        : 0 = op0 + op1, 1 = op0 - op1 (two's complement, op1 inverted plus carry-in)
//   result   : sum/difference modulo 2^16
//   cout     : carry out; in subtract mode 1 means no borrow (op0 >= op1)
module add_subt_16bits
    import arith_pkg::*;
(
    input  logic [WIDTH-1:0] op0,
    input  logic [WIDTH-1:0] op1,
    input  logic             x,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH-1:0] op1_eff;
    logic [WIDTH:0]   sum;

    assign op1_eff = op1 ^ {WIDTH{x}};
    assign sum     = {1'b0, op0} + {1'b0, op1_eff} + {{WIDTH{1'b0}}, x};
    assign result  = sum[WIDTH-1:0];
    assign cout    = sum[WIDTH];

endmodule

// File: rtl/div_seq_16bits.sv
// Sequential 16-bit unsigned restoring divider, one trial subtraction per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request a division (only honoured in IDLE)
//   dividend     : unsigned dividend, captured on the accepted start
//   divisor      : unsigned divisor, captured on the accepted start
//   busy         : high while iterating
//   done         : one-cycle pulse, results valid from this cycle on
//   quotient     : quotient, held until the next accepted start
//   remainder    : remainder, held until the next accepted start
//   div_by_zero  : set with done when divisor was 0
module div_seq_16bits
    import arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] sub_res;
    logic             sub_cout;
    logic             take;

    // Shift the next dividend bit into the partial remainder.
    assign s = {r_q, q_q[WIDTH-1]};

    add_subt_16bits u_sub (
        .op0    (s[WIDTH-1:0]),
        .op1    (d_q),
        .x      (1'b1),
        .result (sub_res),
        .cout   (sub_cout)
    );

    // S[16]=1 means S >= 2^16 > D, so the subtraction always succeeds and
    // the 16-bit result is exact even though cout reports a borrow.
    assign take = s[WIDTH] | sub_cout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_d     = dividend;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        q_d     = '1;
                        r_d     = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                r_d   = take ? sub_res : s[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], take};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status outputs are registered copies of the next state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_16bits.sv
// Scoreboard bench for div_seq_16bits: stimulus pushes expected results
// (value and completion cycle), an independent monitor pops on every done.
module tb_div_seq_16bits;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    div_seq_16bits dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: plain integer division semantics.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int c);
        exp_t e;
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1; e.cyc = c + 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.cyc = c + 17;
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient",    {16'd0, quotient},  {16'd0, mon_e.q});
                chk("remainder",   {16'd0, remainder}, {16'd0, mon_e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
                chk("done_cycle",  cyc, mon_e.cyc);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while ((sb.size() != 0 || done || busy) && n < 200);
        if (n >= 200) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        drain();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b, cyc));
        @(posedge clk); #2;
        start    = 1'b0;
        // Inputs are captured; scrambling them must not matter.
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_quot"}, {16'd0, quotient}, 32'd0);
        chk({tag, "_rem"},  {16'd0, remainder}, 32'd0);
        chk({tag, "_dbz"},  {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        int n;
        logic [15:0] a, b;

        repeat (2) @(posedge clk);
        #2;
        chk_zero("reset");
        rst_n = 1'b1;

        // Directed cases.
        issue(16'd100, 16'd7);
        issue(16'hFFFF, 16'd1);
        issue(16'hFFFF, 16'h8001);
        issue(16'h8000, 16'h8001);
        issue(16'h1234, 16'd0);
        chk("dbz_busy", {31'd0, busy}, 32'd0);

        // Start while busy is ignored.
        issue(16'd500, 16'd3);
        repeat (4) @(posedge clk);
        #2;
        dividend = 16'd9; divisor = 16'd2; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        drain();

        // Start held through the done cycle: only the cycle after done accepts.
        issue(16'd40000, 16'd123);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        chk("b2b_done_seen", {31'd0, done}, 32'd1);
        dividend = 16'd321; divisor = 16'd5; start = 1'b1;
        sb.push_back(model(16'd321, 16'd5, cyc + 1));
        repeat (2) @(posedge clk);
        #2;
        start = 1'b0;
        drain();

        // Reset mid-run aborts with no done.
        issue(16'd1000, 16'd7);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        issue(16'd60000, 16'd250);

        // Randomized operands with a spread of divisor magnitudes.
        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1, 2:    b = 16'($urandom_range(1, 15));
                3:       b = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: b = 16'($urandom);
            endcase
            issue(a, b);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
